// File: rtl/timer_pkg.sv
// Shared definitions for the multichannel countdown timer.
//   ch_state_t : per-channel lifecycle (never loaded / counting / expired one-shot)
//   idx_w      : bit width needed to index n items, never less than 1
package timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } ch_state_t;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/countdown_channel.sv
// One millisecond countdown channel.
// Ports:
//   clk, reset      system clock, synchronous active-high reset
//   tick            one-cycle ms strobe (already gated by global enable)
//   run             1: count on tick, 0: hold
//   auto_reload     1: reload from the reload register on expiry and keep running
//   load            load strobe for this channel (already decoded)
//   load_value      saturated start value in ms
//   value           ms remaining
//   end_reached     level, channel is in DONE
//   expired         one-cycle pulse on 1->0 or on reload
module countdown_channel
  import timer_pkg::*;
#(
  parameter int unsigned CNT_W = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             run,
  input  logic             auto_reload,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  output logic [CNT_W-1:0] value,
  output logic             end_reached,
  output logic             expired
);

  ch_state_t        state;
  logic [CNT_W-1:0] reload_val;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      value       <= '0;
      reload_val  <= '0;
      end_reached <= 1'b0;
      expired     <= 1'b0;
    end else begin
      expired <= 1'b0;
      if (load) begin
        // A load wins over a decrement landing in the same cycle.
        value      <= load_value;
        reload_val <= load_value;
        if (load_value != '0) begin
          state       <= ST_RUN;
          end_reached <= 1'b0;
        end else begin
          state       <= ST_DONE;
          end_reached <= 1'b1;
        end
      end else begin
        case (state)
          ST_RUN: begin
            if (tick && run) begin
              if (value > CNT_W'(1)) begin
                value <= value - CNT_W'(1);
              end else begin
                expired <= 1'b1;
                if (auto_reload) begin
                  value <= reload_val;
                end else begin
                  value       <= '0;
                  state       <= ST_DONE;
                  end_reached <= 1'b1;
                end
              end
            end
          end
          ST_DONE: begin
            value       <= '0;
            end_reached <= 1'b1;
          end
          default: begin
            value       <= '0;
            end_reached <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/multichannel_countdown_timer.sv
// NUM_CH independent millisecond countdown channels sharing one ms prescaler.
// Ports:
//   clk, reset    system clock, synchronous active-high reset
//   enable        global run; low freezes prescaler and every channel
//   load          one-cycle load strobe for channel load_ch
//   load_ch       channel index; indices >= NUM_CH are ignored
//   load_value    start value in ms, saturated to MAX_MS
//   run           per-channel run/pause
//   auto_reload   per-channel reload-on-expiry select
//   timer_value   channel i at [i*CNT_W +: CNT_W], ms remaining
//   end_reached   per-channel DONE level
//   expired       per-channel one-cycle expiry pulse
//   ms_tick       one-cycle pulse per prescaler wrap
module multichannel_countdown_timer
  import timer_pkg::*;
#(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned MAX_MS      = 3000,
  parameter int unsigned CLKS_PER_MS = 50000,
  parameter int unsigned CNT_W       = $clog2(MAX_MS + 1)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      load,
  input  logic [idx_w(NUM_CH)-1:0]  load_ch,
  input  logic [CNT_W-1:0]          load_value,
  input  logic [NUM_CH-1:0]         run,
  input  logic [NUM_CH-1:0]         auto_reload,
  output logic [NUM_CH*CNT_W-1:0]   timer_value,
  output logic [NUM_CH-1:0]         end_reached,
  output logic [NUM_CH-1:0]         expired,
  output logic                      ms_tick
);

  localparam int unsigned      PRE_W    = idx_w(CLKS_PER_MS);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLKS_PER_MS - 1);
  localparam logic [CNT_W-1:0] MAX_V    = CNT_W'(MAX_MS);

  logic [PRE_W-1:0] pre;
  logic             tick;
  logic [CNT_W-1:0] load_sat;
  logic [31:0]      load_idx;

  always_ff @(posedge clk) begin
    if (reset) begin
      pre     <= '0;
      ms_tick <= 1'b0;
    end else if (enable) begin
      ms_tick <= (pre == PRE_LAST);
      pre     <= (pre == PRE_LAST) ? '0 : pre + PRE_W'(1);
    end else begin
      ms_tick <= 1'b0;
    end
  end

  // ms_tick is registered, so a tick raised just before enable drops must
  // not be consumed while the design is frozen.
  assign tick = ms_tick & enable;

  assign load_sat = (load_value > MAX_V) ? MAX_V : load_value;

  // Widened so the range check against NUM_CH stays meaningful when the
  // index width can express more than NUM_CH channels.
  assign load_idx = 32'(load_ch);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic ch_load;
    assign ch_load = load && (load_idx == 32'(i));

    countdown_channel #(
      .CNT_W (CNT_W)
    ) u_ch (
      .clk         (clk),
      .reset       (reset),
      .tick        (tick),
      .run         (run[i]),
      .auto_reload (auto_reload[i]),
      .load        (ch_load),
      .load_value  (load_sat),
      .value       (timer_value[i*CNT_W +: CNT_W]),
      .end_reached (end_reached[i]),
      .expired     (expired[i])
    );
  end

endmodule

// File: tb/tb_multichannel_countdown_timer.sv
module tb_multichannel_countdown_timer;

  localparam int NCH  = 4;
  localparam int MAXV = 20;
  localparam int CPM  = 5;
  localparam int CW   = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset, enable, load;
  logic [1:0]        load_ch;
  logic [CW-1:0]     load_value;
  logic [NCH-1:0]    run, auto_reload;
  logic [NCH*CW-1:0] timer_value;
  logic [NCH-1:0]    end_reached, expired;
  logic              ms_tick;

  multichannel_countdown_timer #(
    .NUM_CH      (NCH),
    .MAX_MS      (MAXV),
    .CLKS_PER_MS (CPM)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .load        (load),
    .load_ch     (load_ch),
    .load_value  (load_value),
    .run         (run),
    .auto_reload (auto_reload),
    .timer_value (timer_value),
    .end_reached (end_reached),
    .expired     (expired),
    .ms_tick     (ms_tick)
  );

  // Three-channel instance: its 2-bit index can address a non-existent channel 3.
  logic           r2_reset, r2_load;
  logic [1:0]     r2_ch;
  logic [CW-1:0]  r2_val;
  logic [3*CW-1:0] r2_tv;
  logic [2:0]     r2_er, r2_ex;
  logic           r2_tick;

  multichannel_countdown_timer #(
    .NUM_CH      (3),
    .MAX_MS      (MAXV),
    .CLKS_PER_MS (CPM)
  ) dut3 (
    .clk         (clk),
    .reset       (r2_reset),
    .enable      (1'b0),
    .load        (r2_load),
    .load_ch     (r2_ch),
    .load_value  (r2_val),
    .run         (3'b111),
    .auto_reload (3'b000),
    .timer_value (r2_tv),
    .end_reached (r2_er),
    .expired     (r2_ex),
    .ms_tick     (r2_tick)
  );

  typedef struct {
    logic [NCH*CW-1:0] tv;
    logic [NCH-1:0]    er;
    logic [NCH-1:0]    ex;
    logic              tk;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: ms remaining per channel, phase of the shared ms clock
  // measured in enabled cycles, and lifecycle 0=idle 1=running 2=done.
  int m_phase;
  bit m_tick;
  int m_val[NCH];
  int m_rel[NCH];
  int m_st[NCH];
  bit m_exp[NCH];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s t=%0t got=%h want=%h", name, $time, got, want);
    end
  endtask

  task automatic model_and_push();
    exp_t e;
    bit   tick_now;
    int   v;
    if (reset) begin
      m_phase = 0;
      m_tick  = 0;
      for (int i = 0; i < NCH; i++) begin
        m_val[i] = 0; m_rel[i] = 0; m_st[i] = 0; m_exp[i] = 0;
      end
    end else begin
      tick_now = m_tick && enable;
      for (int i = 0; i < NCH; i++) begin
        m_exp[i] = 0;
        if (load && int'(load_ch) == i) begin
          v = (int'(load_value) > MAXV) ? MAXV : int'(load_value);
          m_val[i] = v;
          m_rel[i] = v;
          m_st[i]  = (v > 0) ? 1 : 2;
        end else if (m_st[i] == 1 && tick_now && run[i]) begin
          if (m_val[i] > 1) begin
            m_val[i] = m_val[i] - 1;
          end else begin
            m_exp[i] = 1;
            if (auto_reload[i]) m_val[i] = m_rel[i];
            else begin
              m_val[i] = 0;
              m_st[i]  = 2;
            end
          end
        end
      end
      if (enable) begin
        m_phase = (m_phase + 1) % CPM;
        m_tick  = (m_phase == 0);
      end else begin
        m_tick = 0;
      end
    end
    for (int i = 0; i < NCH; i++) begin
      e.tv[i*CW +: CW] = CW'(m_val[i]);
      e.er[i] = (m_st[i] == 2);
      e.ex[i] = m_exp[i];
    end
    e.tk = m_tick;
    sb.push_back(e);
  endtask

  // Inputs are already set; predict the next edge, then move to just after
  // the following negedge so the monitor has consumed that prediction.
  task automatic step();
    model_and_push();
    @(negedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("timer_value", 64'(timer_value), 64'(e.tv));
      check("end_reached", 64'(end_reached), 64'(e.er));
      check("expired", 64'(expired), 64'(e.ex));
      check("ms_tick", 64'(ms_tick), 64'(e.tk));
    end
  end

  initial begin
    reset = 1'b1; enable = 1'b0; load = 1'b0; load_ch = '0; load_value = '0;
    run = '0; auto_reload = '0;
    r2_reset = 1'b1; r2_load = 1'b0; r2_ch = '0; r2_val = '0;

    steps(2);
    reset = 1'b0;
    steps(2);
    enable = 1'b1;
    run = '1;
    steps(12);

    // ch0 one-shot from 3
    load = 1'b1; load_ch = 2'd0; load_value = 5'd3;
    step();
    load = 1'b0;
    steps(25);

    // ch1 auto-reload from 2
    auto_reload[1] = 1'b1;
    load = 1'b1; load_ch = 2'd1; load_value = 5'd2;
    step();
    load = 1'b0;
    steps(30);

    // ch2 from 5, paused, then global freeze, then resume
    load = 1'b1; load_ch = 2'd2; load_value = 5'd5;
    run[2] = 1'b0;
    step();
    load = 1'b0;
    steps(12);
    enable = 1'b0;
    steps(7);
    enable = 1'b1;
    run[2] = 1'b1;
    steps(15);

    // ch3: over-range load saturates (31 is the largest encodable value)
    load = 1'b1; load_ch = 2'd3; load_value = 5'd31;
    step();
    load = 1'b0;
    steps(8);
    load = 1'b1; load_ch = 2'd3; load_value = 5'd0;
    step();
    load = 1'b0;
    steps(6);
    load = 1'b1; load_ch = 2'd3; load_value = 5'd9;
    step();
    load = 1'b0;
    for (int k = 0; k < 2 * CPM && !m_tick; k++) step();
    load = 1'b1; load_ch = 2'd3; load_value = 5'd7;
    step();
    load = 1'b0;
    steps(12);

    // randomized traffic
    for (int k = 0; k < 600; k++) begin
      reset       = ($urandom_range(0, 249) == 0);
      enable      = ($urandom_range(0, 7) != 0);
      run         = NCH'($urandom_range(0, 15)) | NCH'($urandom_range(0, 15));
      if ($urandom_range(0, 19) == 0) auto_reload = NCH'($urandom_range(0, 15));
      load        = ($urandom_range(0, 5) == 0);
      load_ch     = 2'($urandom_range(0, 3));
      load_value  = CW'($urandom_range(0, 31));
      step();
    end
    reset = 1'b0; load = 1'b0; enable = 1'b1; run = '1; auto_reload = '0;

    // reset in the middle of counting on every channel
    for (int i = 0; i < NCH; i++) begin
      load = 1'b1; load_ch = 2'(i); load_value = CW'(4 + i);
      step();
    end
    load = 1'b0;
    steps(13);
    reset = 1'b1;
    step();
    reset = 1'b0;
    steps(12);

    // drain the scoreboard
    @(negedge clk);
    #1;
    check("scoreboard_drained", 64'(sb.size()), 64'd0);

    // out-of-range channel index on the three-channel instance
    r2_reset = 1'b0;
    r2_load = 1'b1; r2_ch = 2'd3; r2_val = 5'd5;
    @(negedge clk); #1;
    r2_load = 1'b0;
    @(negedge clk); #1;
    check("oob_load_values", 64'(r2_tv), 64'd0);
    check("oob_load_end", 64'(r2_er), 64'd0);
    check("oob_load_expired", 64'(r2_ex), 64'd0);
    r2_load = 1'b1; r2_ch = 2'd2; r2_val = 5'd5;
    @(negedge clk); #1;
    r2_load = 1'b0;
    check("ch2_load_3ch", 64'(r2_tv), 64'(15'd5 << 10));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
